npu_ctrl_seq: RTL and testbench

//  Parametrised successor of the 8-bit NPU control FSM: sequences N_PHASE control words per layer over
//  N_LAYERS layers, with a start delay (DB) and per-phase dwell (DD), driving CON_SIG to the MAC/memory datapath.

---
 rtl/npu_fsm_pkg.sv | 14 +
 rtl/npu_down_counter.sv | 46 ++++
 rtl/npu_ctrl_seq.sv | 215 +++++++++++++++++++++
 tb/tb_npu_ctrl_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_fsm_pkg.sv
// Shared header for the NPU control sequencer.
// Holds the FSM state encoding used by npu_ctrl_seq.
package npu_fsm_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_RUN   = 2'd2,
        S_FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/npu_down_counter.sv
// Loadable down-counter with terminal count at 1.
// Ports:
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-high reset (count -> 0)
//   load_i     load load_val_i (has priority over en_i)
//   load_val_i value to load
//   en_i       decrement by one; saturates at 0
//   tc_o       high while the count equals 1 (last cycle of the interval)
module npu_down_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, otherwise decrement without ever wrapping below 0.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/npu_ctrl_seq.sv
// NPU control sequencer: after an optional start delay, steps through
// N_PHASE control words per layer, each held for a dwell time, over a
// programmable number of layers, then pulses DONE.
// Ports:
//   CLKEXT     clock, rising edge
//   RST        asynchronous active-high reset
//   EN_FSM     1 = run, 0 = pause (state/counters frozen, CON_SIG = 0)
//   START      start request, honoured in IDLE only
//   ABORT      synchronous return to IDLE, beats everything except RST
//   DB         start-delay cycles (latched on START)
//   DD         dwell cycles per phase (latched on START, 0 acts as 1)
//   N_LAYERS   layer count (latched on START, 0 acts as 1)
//   PHASE_WORD packed control words, phase p at [p*CW +: CW], read live
//   CON_SIG    registered control word
//   BUSY       high in DELAY/RUN
//   DONE       one-cycle completion pulse
//   PHASE      current phase index
//   LAYER      current layer index
module npu_ctrl_seq
    import npu_fsm_pkg::*;
#(
    parameter int CW      = 16,
    parameter int CNT_W   = 8,
    parameter int N_PHASE = 4,
    parameter int LAYER_W = 4,
    parameter int PH_W    = $clog2(N_PHASE)
) (
    input  logic                  CLKEXT,
    input  logic                  RST,
    input  logic                  EN_FSM,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic [CNT_W-1:0]      DB,
    input  logic [CNT_W-1:0]      DD,
    input  logic [LAYER_W-1:0]    N_LAYERS,
    input  logic [N_PHASE*CW-1:0] PHASE_WORD,
    output logic [CW-1:0]         CON_SIG,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [PH_W-1:0]       PHASE,
    output logic [LAYER_W-1:0]    LAYER
);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(N_PHASE - 1);

    state_t               state_q, state_d;
    logic [CW-1:0]        con_sig_q, con_sig_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic [LAYER_W-1:0]   layer_q, layer_d;
    logic [CNT_W-1:0]     dd_q, dd_d;
    logic [LAYER_W-1:0]   nl_q, nl_d;

    logic                 dly_load_s, dly_en_s, dly_tc_s;
    logic                 dwl_load_s, dwl_en_s, dwl_tc_s;
    logic [CNT_W-1:0]     dwl_val_s;
    logic [CNT_W-1:0]     dd_start_s;
    logic [LAYER_W-1:0]   nl_start_s;

    // Zero dwell / zero layers are promoted to one at the moment they are latched.
    always_comb begin
        if (DD == {CNT_W{1'b0}}) begin
            dd_start_s = CNT_W'(1);
        end else begin
            dd_start_s = DD;
        end
        if (N_LAYERS == {LAYER_W{1'b0}}) begin
            nl_start_s = LAYER_W'(1);
        end else begin
            nl_start_s = N_LAYERS;
        end
    end

    npu_down_counter #(.CNT_W(CNT_W)) u_delay_cnt (
        .clk_i      (CLKEXT),
        .rst_i      (RST),
        .load_i     (dly_load_s),
        .load_val_i (DB),
        .en_i       (dly_en_s),
        .tc_o       (dly_tc_s)
    );

    npu_down_counter #(.CNT_W(CNT_W)) u_dwell_cnt (
        .clk_i      (CLKEXT),
        .rst_i      (RST),
        .load_i     (dwl_load_s),
        .load_val_i (dwl_val_s),
        .en_i       (dwl_en_s),
        .tc_o       (dwl_tc_s)
    );

    // Next-state, phase/layer stepping and registered-output values.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        phase_d    = phase_q;
        layer_d    = layer_q;
        dd_d       = dd_q;
        nl_d       = nl_q;
        dly_load_s = 1'b0;
        dly_en_s   = 1'b0;
        dwl_load_s = 1'b0;
        dwl_en_s   = 1'b0;
        dwl_val_s  = dd_q;
        con_sig_d  = {CW{1'b0}};

        if (ABORT) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            phase_d = {PH_W{1'b0}};
            layer_d = {LAYER_W{1'b0}};
        end else if (!EN_FSM) begin
            // Paused: hold everything; CON_SIG falls to 0 below and no count is consumed.
            state_d = state_q;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        dd_d    = dd_start_s;
                        nl_d    = nl_start_s;
                        phase_d = {PH_W{1'b0}};
                        layer_d = {LAYER_W{1'b0}};
                        busy_d  = 1'b1;
                        if (DB != {CNT_W{1'b0}}) begin
                            state_d    = S_DELAY;
                            dly_load_s = 1'b1;
                        end else begin
                            // Latched dd_q is not valid yet, so load the dwell from the live input.
                            state_d    = S_RUN;
                            dwl_load_s = 1'b1;
                            dwl_val_s  = dd_start_s;
                        end
                    end else begin
                        busy_d = 1'b0;
                    end
                end
                S_DELAY: begin
                    if (dly_tc_s) begin
                        state_d    = S_RUN;
                        dwl_load_s = 1'b1;
                    end else begin
                        dly_en_s = 1'b1;
                    end
                end
                S_RUN: begin
                    if (dwl_tc_s) begin
                        dwl_load_s = 1'b1;
                        if (phase_q == PH_LAST) begin
                            phase_d = {PH_W{1'b0}};
                            if (layer_q == (nl_q - LAYER_W'(1))) begin
                                state_d = S_FIN;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                layer_d = {LAYER_W{1'b0}};
                            end else begin
                                layer_d = layer_q + LAYER_W'(1);
                            end
                        end else begin
                            phase_d = phase_q + PH_W'(1);
                        end
                    end else begin
                        dwl_en_s = 1'b1;
                    end
                end
                S_FIN: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end

        // The word follows the phase being entered/held, read live from PHASE_WORD.
        if (!ABORT && EN_FSM && (state_d == S_RUN)) begin
            con_sig_d = PHASE_WORD[phase_d*CW +: CW];
        end else begin
            con_sig_d = {CW{1'b0}};
        end
    end

    // State, latched configuration and output registers.
    always_ff @(posedge CLKEXT or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            con_sig_q <= {CW{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            phase_q   <= {PH_W{1'b0}};
            layer_q   <= {LAYER_W{1'b0}};
            dd_q      <= {CNT_W{1'b0}};
            nl_q      <= {LAYER_W{1'b0}};
        end else begin
            state_q   <= state_d;
            con_sig_q <= con_sig_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            phase_q   <= phase_d;
            layer_q   <= layer_d;
            dd_q      <= dd_d;
            nl_q      <= nl_d;
        end
    end

    assign CON_SIG = con_sig_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign PHASE   = phase_q;
    assign LAYER   = layer_q;

endmodule

// File: tb/tb_npu_ctrl_seq.sv
`timescale 1ns/1ps
module tb_npu_ctrl_seq;

    localparam int CW      = 16;
    localparam int CNT_W   = 8;
    localparam int N_PHASE = 4;
    localparam int LAYER_W = 4;
    localparam int PH_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic                  start;
    logic                  abort;
    logic [CNT_W-1:0]      db;
    logic [CNT_W-1:0]      dd;
    logic [LAYER_W-1:0]    nl;
    logic [N_PHASE*CW-1:0] pw;
    logic [CW-1:0]         con;
    logic                  busy;
    logic                  done;
    logic [PH_W-1:0]       phase;
    logic [LAYER_W-1:0]    layer;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    npu_ctrl_seq #(
        .CW(CW), .CNT_W(CNT_W), .N_PHASE(N_PHASE), .LAYER_W(LAYER_W)
    ) dut (
        .CLKEXT     (clk),
        .RST        (rst),
        .EN_FSM     (en),
        .START      (start),
        .ABORT      (abort),
        .DB         (db),
        .DD         (dd),
        .N_LAYERS   (nl),
        .PHASE_WORD (pw),
        .CON_SIG    (con),
        .BUSY       (busy),
        .DONE       (done),
        .PHASE      (phase),
        .LAYER      (layer)
    );

    typedef struct {
        int db;
        int dd;
        int nl;
        int exp_busy;   // hand-computed DB + 4*max(DD,1)*max(NL,1)
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Words are programmed as one-hot 1,2,4,8 for phases 0..3.
    function automatic int exp_word(input int p);
        return 1 << p;
    endfunction

    // Start one run and follow it cycle by cycle against a small model.
    task automatic run_vec(input vec_t v, input string nm);
        int dde, busy_cnt, done_cnt, done_at, first_nz, trace_err, j, ph, ly;
        dde = (v.dd == 0) ? 1 : v.dd;
        db = 8'(v.db);
        dd = 8'(v.dd);
        nl = 4'(v.nl);
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at = -1; first_nz = -1; trace_err = 0;
        for (int i = 0; i < v.exp_busy + 4; i++) begin
            busy_cnt += int'(busy);
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (con != 16'd0 && first_nz < 0) first_nz = i;
            if (i >= v.db && i < v.exp_busy) begin
                j  = i - v.db;
                ph = (j / dde) % N_PHASE;
                ly = j / (dde * N_PHASE);
                if (int'(con) != exp_word(ph) || int'(phase) != ph || int'(layer) != ly) trace_err++;
            end else if (con != 16'd0) begin
                trace_err++;
            end
            tick();
        end
        check({nm, " busy_cycles"}, busy_cnt, v.exp_busy);
        check({nm, " done_count"}, done_cnt, 1);
        check({nm, " done_cycle"}, done_at, v.exp_busy);
        check({nm, " first_word_cycle"}, first_nz, v.db);
        check({nm, " trace_errors"}, trace_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, done_cnt, done_at, trace_err, ec;

        vecs[0] = '{2, 3, 2, 26};
        vecs[1] = '{0, 0, 0, 4};
        vecs[2] = '{1, 1, 1, 5};
        vecs[3] = '{0, 2, 3, 24};
        vecs[4] = '{5, 1, 0, 9};

        rst = 1'b1; en = 1'b0; start = 1'b0; abort = 1'b0;
        db = 8'd0; dd = 8'd0; nl = 4'd0;
        pw = {16'h0008, 16'h0004, 16'h0002, 16'h0001};

        // Reset, then START with EN_FSM low must be ignored.
        #11;
        check("reset con", int'(con), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset phase", int'(phase), 0);
        check("reset layer", int'(layer), 0);
        #1 rst = 1'b0;
        start = 1'b1;
        busy_cnt = 0; ec = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            busy_cnt += int'(busy);
            if (con != 16'd0) ec++;
        end
        start = 1'b0;
        check("paused start busy", busy_cnt, 0);
        check("paused start con", ec, 0);
        en = 1'b1;
        tick();

        // Table-driven runs.
        for (int k = 0; k < 5; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k));
        end

        // Pause for 5 cycles in phase 2 with 2 dwell cycles left.
        db = 8'd0; dd = 8'd3; nl = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at = -1; trace_err = 0;
        for (int i = 0; i < 22; i++) begin
            if (i < 6)       ec = 1 << (i / 3);
            else if (i == 6) ec = 4;
            else if (i < 12) ec = 0;
            else if (i < 14) ec = 4;
            else if (i < 17) ec = 8;
            else             ec = 0;
            if (int'(con) != ec) trace_err++;
            busy_cnt += int'(busy);
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            en = (i >= 6 && i <= 10) ? 1'b0 : 1'b1;
            tick();
        end
        check("pause trace_errors", trace_err, 0);
        check("pause busy_cycles", busy_cnt, 17);
        check("pause done_cycle", done_at, 17);
        check("pause done_count", done_cnt, 1);

        // ABORT in layer 1 phase 3.
        db = 8'd0; dd = 8'd1; nl = 4'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        check("abort pre layer", int'(layer), 1);
        check("abort pre phase", int'(phase), 3);
        check("abort pre con", int'(con), 8);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort con", int'(con), 0);
        check("abort busy", int'(busy), 0);
        done_cnt = int'(done);
        for (int i = 0; i < 6; i++) begin
            tick();
            done_cnt += int'(done) + int'(busy);
        end
        check("abort no done", done_cnt, 0);

        // ABORT together with START in IDLE: ABORT wins.
        abort = 1'b1; start = 1'b1; db = 8'd0; dd = 8'd1; nl = 4'd1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort+start busy", int'(busy), 0);
        check("abort+start con", int'(con), 0);
        tick();
        check("abort+start busy later", int'(busy), 0);

        run_vec('{1, 1, 1, 5}, "after_abort");

        // Asynchronous reset between edges in DELAY.
        db = 8'd5; dd = 8'd1; nl = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("delay busy before rst", int'(busy), 1);
        #3 rst = 1'b1;
        #1;
        check("async rst busy", int'(busy), 0);
        check("async rst con", int'(con), 0);
        #2 rst = 1'b0;
        done_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            done_cnt += int'(done);
            busy_cnt += int'(busy);
        end
        check("after rst done", done_cnt, 0);
        check("after rst busy", busy_cnt, 0);

        // START repeated while busy is ignored.
        db = 8'd0; dd = 8'd1; nl = 4'd1;
        start = 1'b1;
        tick();
        done_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            busy_cnt += int'(busy);
            done_cnt += int'(done);
            if (i == 1) start = 1'b0;
            tick();
        end
        check("restart ignored busy", busy_cnt, 4);
        check("restart ignored done", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
